alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit ctrlSignal produced by the ALU control decoder.
//  Accepts one operation per valid/ready handshake, registers the result, and presents it downstream with its own handshake.
//  Single-cycle ops complete in 1 cycle; the optional multiply is iterative (shift-add).
//  Sits between operand fetch/decode and write-back/memory stage.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rstN        in   1      asynchronous, active-low reset
//  inValid     in   1      operation request valid
//  inReady     out  1      unit can accept a request this cycle
//  ctrlSignal  in   4      operation code (see BEHAVIOUR)
//  srcA        in   WIDTH  operand A
//  srcB        in   WIDTH  operand B
//  outValid    out  1      result valid
//  outReady    in   1      downstream accepts result
//  result      out  WIDTH  registered result
//  zero        out  1      registered (result == 0)
//  illegal     out  1      registered: ctrlSignal was unsupported
// BEHAVIOUR
//  - Reset (rstN low, async): state=IDLE, outValid=0, result=0, zero=0, illegal=0, internal counter/accumulator=0.
//  - Op codes: 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0110 SUB srcA-srcB (mod 2^WIDTH);
//    0111 SLT signed (result = {WIDTH-1 zeros, srcA<srcB}); 1000 MUL (low WIDTH bits, only with ALU_MUL_EN);
//    any other code: result=0, illegal=1, latency as single-cycle op.
//  - Accept = inValid && inReady; operands and code are captured on accept only.
//  - States: IDLE, MUL, DONE.
//  - IDLE: inReady=1, outValid=0. On accept of a single-cycle op -> DONE, with result/zero/illegal written that edge.
//    On accept of MUL -> MUL, with counter=0 and acc=0.
//  - MUL: inReady=0, outValid=0. Each cycle: if multiplier bit0, acc+=multiplicand.
//    Then multiplicand<<=1, multiplier>>=1, counter++.
//    After WIDTH iterations -> DONE with result=acc, illegal=0.
//  - DONE: outValid=1; result/zero/illegal held stable while outReady=0.
//    inReady = outReady (back-to-back issue).
//    outReady=1 and no accept -> IDLE.
//    outReady=1 and accept -> new op processed exactly as from IDLE; no bubble for single-cycle ops.
//  - Latency (accept to outValid): single-cycle/illegal = 1 cycle; MUL = WIDTH+1 cycles.
//  - Throughput: 1 op/cycle for single-cycle ops under continuous outReady.
//  - inValid while inReady=0 is ignored; the requester holds its request.
//  - ctrlSignal/srcA/srcB changes after accept have no effect on the in-flight op.
//  - zero is computed from the value written to result (illegal op -> zero=1).
//  - Reset mid-MUL or mid-DONE: op discarded, no outValid pulse; the unit is in IDLE on the first edge after rstN rises.
// CONFIGURATION
//  ALU_MUL_EN defined: code 1000 runs the iterative multiplier (MUL state, counter, accumulator present).
//  ALU_MUL_EN undefined: no MUL state or datapath.
//    Code 1000 is illegal: result=0, illegal=1, 1-cycle latency.
// TESTING
//  1 ADD srcA=32'hFFFFFFFF srcB=1 -> next cycle outValid=1, result=0, zero=1, illegal=0.
//  2 SUB 5-7 -> result=32'hFFFFFFFE, zero=0.
//    SLT srcA=32'hFFFFFFFF srcB=1 -> result=1.
//    AND 32'hF0F0_F0F0 & 32'h0FF0_0FF0 -> 32'h00F0_00F0.
//  3 Backpressure: OR result pending with outReady=0 for 3 cycles -> outValid, result and zero stable; inReady=0.
//    outReady=1 with a new ADD accepted -> the ADD result appears the next cycle.
//  4 MUL 7*6 (ALU_MUL_EN): outValid rises exactly 33 cycles after accept with result=42, inReady=0 meanwhile.
//    32'h8000_0000*2 -> 0.
//    Without macro: same MUL -> 1 cycle later, illegal=1, result=0.
//  5 Illegal code 4'b0011 -> result=0, zero=1, illegal=1.
//    Next legal op clears illegal.
//  6 Assert rstN low 10 cycles into a MUL -> outValid=0, result=0 immediately.
//    After release the unit accepts a new ADD and completes normally.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between operand fetch, the execute ALU and write-back.
// The requester/consumer side uses master; the ALU uses slave.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             inValid;
  logic             inReady;
  logic [3:0]       ctrlSignal;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output inValid, ctrlSignal, srcA, srcB, outReady,
    input  inReady, outValid, result, zero, illegal
  );

  modport slave (
    input  inValid, ctrlSignal, srcA, srcB, outReady,
    output inReady, outValid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered result.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (code 1000).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstN,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CNT_W  = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MUL_EN
    ,S_MUL = 2'd2
`endif
  } state_t;

  state_t           state, state_next;
  logic             in_ready, out_valid, accept, is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, illegal_q;

  assign accept = bus.inValid && in_ready;
`ifdef ALU_MUL_EN
  assign is_mul = (bus.ctrlSignal == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle datapath; unsupported codes fall through to the illegal default.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.ctrlSignal)
      OP_AND:  alu_res = bus.srcA & bus.srcB;
      OP_OR:   alu_res = bus.srcA | bus.srcB;
      OP_ADD:  alu_res = bus.srcA + bus.srcB;
      OP_SUB:  alu_res = bus.srcA - bus.srcB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CNT_W-1:0] counter;
  logic             mul_last;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (counter == CNT_W'(WIDTH-1));
`endif

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rstN) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; DONE with an accept behaves exactly like IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mul ? state_t'(2'd2) : S_DONE;
      S_DONE: begin
        if (accept)            state_next = is_mul ? state_t'(2'd2) : S_DONE;
        else if (bus.outReady) state_next = S_IDLE;
      end
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_last) state_next = S_DONE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.outReady;
      end
      default: ;
    endcase
  end

  // Result registers and multiplier datapath
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      counter <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= alu_ill;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        mcand   <= bus.srcA;
        mplier  <= bus.srcB;
        acc     <= '0;
        counter <= '0;
      end else if (state == S_MUL) begin
        acc     <= acc_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        counter <= counter + 1'b1;
        // Final iteration folds its partial product straight into the result.
        if (mul_last) begin
          result_q  <= acc_next;
          zero_q    <= (acc_next == '0);
          illegal_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic
// checked against a transaction-level reference model (honours ALU_MUL_EN).
module tb_alu_exec_unit;
  localparam int WIDTH = 32;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = WIDTH + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: at most one op in flight, visible from cycle m_done on.
  logic        m_busy = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_ill = 1'b0;
  int          m_done = 0;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
    r = 32'd0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'b1000: begin r = a * b; lat = MUL_LAT; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // One cycle: drive at negedge, then compare DUT against the model.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, output logic took);
    logic        ov_exp, ir_exp, il;
    logic [31:0] r;
    int          lat;
    @(negedge clk);
    bus.inValid = v;
    bus.ctrlSignal = op;
    bus.srcA = a;
    bus.srcB = b;
    bus.outReady = ordy;
    #1;
    ov_exp = m_busy && (cyc >= m_done);
    ir_exp = !m_busy || (ov_exp && ordy);
    check("out_valid", {31'd0, bus.outValid}, {31'd0, ov_exp});
    check("in_ready", {31'd0, bus.inReady}, {31'd0, ir_exp});
    if (ov_exp) begin
      check("result", bus.result, m_res);
      check("zero", {31'd0, bus.zero}, {31'd0, (m_res == 32'd0)});
      check("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
    end
    if (ov_exp && ordy) m_busy = 1'b0;
    took = v && ir_exp;
    if (took) begin
      ref_op(op, a, b, r, il, lat);
      m_busy = 1'b1;
      m_res = r;
      m_ill = il;
      m_done = cyc + lat;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rstN = 1'b0;
    bus.inValid = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.outValid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    m_busy = 1'b0;
    repeat (cycles) @(negedge clk);
    rstN = 1'b1;
  endtask

  // Issue one op with outReady high and return its observed latency and outputs.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic ill);
    logic took;
    lat = 0;
    res = 'x;
    ill = 1'bx;
    step(1'b1, op, a, b, 1'b1, took);
    check("run_op_accept", {31'd0, took}, 32'd1);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, took);
      if (bus.outValid) begin
        lat = i;
        res = bus.result;
        ill = bus.illegal;
        break;
      end
    end
    if (lat == 0) check("run_op_timeout", 32'd0, 32'd1);
  endtask

  logic        took, hold;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b, res;
  logic        ill;
  int          lat;
  logic [3:0]  op_tab [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                                4'b1000, 4'b0011, 4'b0100, 4'b1001, 4'b1111};

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000 >> $urandom_range(0, 31);
      2: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.inValid = 1'b0;
    bus.ctrlSignal = 4'd0;
    bus.srcA = '0;
    bus.srcB = '0;
    bus.outReady = 1'b0;
    do_reset(3);

    // Wrap-around ADD, SUB, signed SLT, AND
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, lat, res, ill);
    check("add_lat", 32'(lat), 32'd1);
    check("add_wrap", res, 32'd0);
    check("add_zero", {31'd0, bus.zero}, 32'd1);
    run_op(4'b0110, 32'd5, 32'd7, lat, res, ill);
    check("sub_neg", res, 32'hFFFF_FFFE);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, lat, res, ill);
    check("slt_signed", res, 32'd1);
    run_op(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, res, ill);
    check("and", res, 32'h00F0_00F0);

    // Backpressure: OR pending, then ADD issued back-to-back on release
    step(1'b1, 4'b0001, 32'h1200_0034, 32'h0000_5600, 1'b0, took);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 32'd100, 32'd23, 1'b0, took);
    check("bp_held_off", {31'd0, took}, 32'd0);
    step(1'b1, 4'b0010, 32'd100, 32'd23, 1'b1, took);
    check("bp_accept", {31'd0, took}, 32'd1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, took);
    check("bp_add_res", bus.result, 32'd123);

    // Multiply (or illegal 1000 without the multiplier)
    run_op(4'b1000, 32'd7, 32'd6, lat, res, ill);
    check("mul_lat", 32'(lat), 32'(MUL_LAT));
`ifdef ALU_MUL_EN
    check("mul_7x6", res, 32'd42);
    run_op(4'b1000, 32'h8000_0000, 32'd2, lat, res, ill);
    check("mul_ovf", res, 32'd0);
`else
    check("mul_ill", {31'd0, ill}, 32'd1);
    check("mul_ill_res", res, 32'd0);
`endif

    // Illegal code, then a legal op clears the flag
    run_op(4'b0011, 32'd9, 32'd9, lat, res, ill);
    check("ill_flag", {31'd0, ill}, 32'd1);
    check("ill_res", res, 32'd0);
    run_op(4'b0001, 32'd1, 32'd2, lat, res, ill);
    check("ill_cleared", {31'd0, ill}, 32'd0);

    // Reset in the middle of an op, then a normal ADD
    step(1'b1, 4'b1000, 32'd3, 32'd3, 1'b1, took);
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, took);
    do_reset(2);
    run_op(4'b0010, 32'd40, 32'd2, lat, res, ill);
    check("post_rst_add", res, 32'd42);
    check("post_rst_lat", 32'(lat), 32'd1);

    // Randomized traffic; a refused request is held unchanged
    hold = 1'b0;
    r_op = 4'd0;
    r_a = '0;
    r_b = '0;
    for (int i = 0; i < 1500; i++) begin
      logic v;
      if (hold) v = 1'b1;
      else begin
        v = ($urandom_range(0, 9) < 7);
        r_op = op_tab[$urandom_range(0, 9)];
        if (r_op == 4'b1000 && $urandom_range(0, 3) != 0) r_op = 4'b0010;
        r_a = pick_operand();
        r_b = pick_operand();
      end
      step(v, r_op, r_a, r_b, ($urandom_range(0, 9) < 7), took);
      hold = v && !took;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
